// File: rtl/ofm_pkt_fifo.sv
// ofm_pkt_fifo: store-and-forward TX packet FIFO (tx_clk domain) feeding the
// 10G MAC transmit stream. Frames become visible to the reader only once
// their last beat has been stored. Bad frames (tuser on tlast) and frames
// larger than the whole buffer are dropped by rewinding the write pointer.
// Optional build macro OFM_PKT_STATS_EN adds 32-bit wrapping counters for
// transmitted packets, bad-frame drops and oversize drops.
module ofm_pkt_fifo #(
    parameter int DATA_W       = 64,
    parameter int DEPTH_LOG2   = 9,
    parameter int PKT_LOG2     = 8,
    parameter int AFULL_THRESH = 448
) (
    input  logic                tx_clk,
    input  logic                sys_rst_n,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic                s_axis_tuser,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   tx_axis_mac_tdata,
    output logic [DATA_W/8-1:0] tx_axis_mac_tkeep,
    output logic                tx_axis_mac_tlast,
    output logic                tx_axis_mac_tuser,
    output logic                tx_axis_mac_tvalid,
    input  logic                tx_axis_mac_tready,
    output logic                fifo_afull,
    output logic [PKT_LOG2-1:0] pkt_cnt,
    output logic                drop_pulse
`ifdef OFM_PKT_STATS_EN
    ,
    output logic [31:0]         stat_tx_pkts,
    output logic [31:0]         stat_drop_bad,
    output logic [31:0]         stat_drop_oversize
`endif
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int ENT_W  = DATA_W + KEEP_W + 1;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam logic [PTR_W-1:0]    AFULL_V = PTR_W'(AFULL_THRESH);
    localparam logic [PKT_LOG2-1:0] PKT_MAX = '1;

    typedef enum logic {ST_STORE, ST_DISCARD} wr_state_t;

    wr_state_t state;
    wr_state_t state_nxt;

    // Pointers carry one extra MSB so a full buffer differs from an empty one.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_commit;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] used;
    logic             full;

    logic             wr_acc;
    logic             commit;
    logic             bad_drop;
    logic             enter_discard;

    logic             rd_en;
    logic             move_p1;
    logic             pop;
    logic             pop_last;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [ENT_W-1:0]  rd_data_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p2;
    logic [KEEP_W-1:0] keep_p2;
    logic              last_p2;
    logic              vld_p2;

    assign used = wr_ptr - rd_ptr;
    assign full = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign wr_acc   = (state == ST_STORE) && s_axis_tvalid && s_axis_tready;
    assign commit   = wr_acc && s_axis_tlast && !s_axis_tuser;
    assign bad_drop = wr_acc && s_axis_tlast && s_axis_tuser;

    // Write FSM state register.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            state <= ST_STORE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM next state and ready. A full buffer holding no committed frame
    // and an idle reader can never make room, so the frame in flight is dropped.
    always_comb begin
        state_nxt     = state;
        s_axis_tready = 1'b0;
        enter_discard = 1'b0;
        case (state)
            ST_STORE: begin
                s_axis_tready = !full && (pkt_cnt != PKT_MAX);
                if (full && (pkt_cnt == '0) && !vld_p1 && !vld_p2) begin
                    state_nxt     = ST_DISCARD;
                    enter_discard = 1'b1;
                end
            end
            ST_DISCARD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_nxt = ST_STORE;
                end
            end
            default: state_nxt = ST_STORE;
        endcase
    end

    // Speculative write pointer, commit point and drop pulse; drops rewind to the commit point.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            wr_commit  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= 1'b0;
            if (enter_discard) begin
                wr_ptr     <= wr_commit;
                drop_pulse <= 1'b1;
            end else if (bad_drop) begin
                wr_ptr     <= wr_commit;
                drop_pulse <= 1'b1;
            end else if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (s_axis_tlast) begin
                    wr_commit <= wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Buffer write port: every accepted beat in ST_STORE lands at wr_ptr.
    always_ff @(posedge tx_clk) begin
        if (wr_acc) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // Read stage p1: RAM output holds its beat until the output register can take it.
    assign move_p1 = vld_p1 && (!vld_p2 || tx_axis_mac_tready);
    assign rd_en   = (rd_ptr != wr_commit) && (!vld_p1 || move_p1);

    // Read pointer and p1 valid; reads never pass the commit point.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            rd_ptr <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                vld_p1 <= 1'b1;
            end else if (move_p1) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    // Buffer read port with one cycle of latency.
    always_ff @(posedge tx_clk) begin
        if (rd_en) begin
            rd_data_p1 <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // Read stage p2: one-entry output register, held while the MAC stalls.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else if (move_p1) begin
            vld_p2  <= 1'b1;
            last_p2 <= rd_data_p1[ENT_W-1];
        end else if (tx_axis_mac_tready) begin
            vld_p2  <= 1'b0;
        end
    end

    // Output data and keep follow the p2 load strobe.
    always_ff @(posedge tx_clk) begin
        if (move_p1) begin
            data_p2 <= rd_data_p1[DATA_W-1:0];
            keep_p2 <= rd_data_p1[DATA_W +: KEEP_W];
        end
    end

    assign pop      = vld_p2 && tx_axis_mac_tready;
    assign pop_last = pop && last_p2;

    // Committed packet count: up on commit, down when the MAC takes a last beat.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            pkt_cnt <= '0;
        end else begin
            case ({commit, pop_last})
                2'b10:   pkt_cnt <= pkt_cnt + PKT_LOG2'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PKT_LOG2'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Almost-full flag registered from the used-beat count.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            fifo_afull <= 1'b0;
        end else begin
            fifo_afull <= (used >= AFULL_V);
        end
    end

    assign tx_axis_mac_tdata  = data_p2;
    assign tx_axis_mac_tkeep  = keep_p2;
    assign tx_axis_mac_tlast  = last_p2;
    assign tx_axis_mac_tvalid = vld_p2;
    assign tx_axis_mac_tuser  = 1'b0;

`ifdef OFM_PKT_STATS_EN
    // Wrapping statistics counters.
    always_ff @(posedge tx_clk) begin
        if (!sys_rst_n) begin
            stat_tx_pkts       <= '0;
            stat_drop_bad      <= '0;
            stat_drop_oversize <= '0;
        end else begin
            if (pop_last) begin
                stat_tx_pkts <= stat_tx_pkts + 32'd1;
            end
            if (bad_drop) begin
                stat_drop_bad <= stat_drop_bad + 32'd1;
            end
            if (enter_discard) begin
                stat_drop_oversize <= stat_drop_oversize + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ofm_pkt_fifo.sv
// Testbench for ofm_pkt_fifo: random frames driven into the write port, a
// queue of expected MAC beats filled as frames commit, and an independent
// monitor that pops and compares every beat the MAC accepts.
module tb_ofm_pkt_fifo;

    localparam int DATA_W       = 64;
    localparam int KEEP_W       = DATA_W / 8;
    localparam int DEPTH_LOG2   = 9;
    localparam int PKT_LOG2     = 8;
    localparam int AFULL_THRESH = 448;
    localparam int DEPTH        = 2 ** DEPTH_LOG2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic                tx_clk = 1'b0;
    logic                sys_rst_n;
    logic [DATA_W-1:0]   s_axis_tdata;
    logic [KEEP_W-1:0]   s_axis_tkeep;
    logic                s_axis_tlast;
    logic                s_axis_tuser;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic [DATA_W-1:0]   tx_axis_mac_tdata;
    logic [KEEP_W-1:0]   tx_axis_mac_tkeep;
    logic                tx_axis_mac_tlast;
    logic                tx_axis_mac_tuser;
    logic                tx_axis_mac_tvalid;
    logic                tx_axis_mac_tready;
    logic                fifo_afull;
    logic [PKT_LOG2-1:0] pkt_cnt;
    logic                drop_pulse;
`ifdef OFM_PKT_STATS_EN
    logic [31:0]         stat_tx_pkts;
    logic [31:0]         stat_drop_bad;
    logic [31:0]         stat_drop_oversize;
`endif

    ofm_pkt_fifo #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2),
        .PKT_LOG2(PKT_LOG2), .AFULL_THRESH(AFULL_THRESH)
    ) dut (
        .tx_clk(tx_clk), .sys_rst_n(sys_rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .tx_axis_mac_tdata(tx_axis_mac_tdata), .tx_axis_mac_tkeep(tx_axis_mac_tkeep),
        .tx_axis_mac_tlast(tx_axis_mac_tlast), .tx_axis_mac_tuser(tx_axis_mac_tuser),
        .tx_axis_mac_tvalid(tx_axis_mac_tvalid), .tx_axis_mac_tready(tx_axis_mac_tready),
        .fifo_afull(fifo_afull), .pkt_cnt(pkt_cnt), .drop_pulse(drop_pulse)
`ifdef OFM_PKT_STATS_EN
        ,
        .stat_tx_pkts(stat_tx_pkts), .stat_drop_bad(stat_drop_bad),
        .stat_drop_oversize(stat_drop_oversize)
`endif
    );

    always #5 tx_clk = ~tx_clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t exp_q[$];
    int    commits    = 0;
    int    lasts      = 0;
    int    drops_exp  = 0;
    int    drops_seen = 0;
    bit    rdy_rand   = 1'b0;
    logic  rdy_fixed  = 1'b1;
    bit    hold_v     = 1'b0;
    beat_t hold_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic check_beat(input string name, input beat_t act, input beat_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got data=%h keep=%h last=%b want data=%h keep=%h last=%b",
                     name, act.data, act.keep, act.last, req.data, req.keep, req.last);
        end
    endtask

    // MAC ready: fixed level or 50% random, changed just after each edge.
    initial begin
        tx_axis_mac_tready = 1'b0;
        forever begin
            @(posedge tx_clk);
            #1;
            tx_axis_mac_tready = rdy_rand ? logic'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // Monitor: packet count, output stability under back-pressure, beat scoreboard.
    always @(negedge tx_clk) begin
        beat_t cur;
        beat_t e;
        cur = '{data: tx_axis_mac_tdata, keep: tx_axis_mac_tkeep, last: tx_axis_mac_tlast};
        if (!sys_rst_n) begin
            hold_v = 1'b0;
        end else begin
            check("pkt_cnt", 64'(pkt_cnt), 64'(PKT_LOG2'(commits - lasts)));
            if (hold_v) begin
                check("hold_valid", 64'(tx_axis_mac_tvalid), 64'(1));
                check_beat("hold_beat", cur, hold_b);
            end
            if (drop_pulse) drops_seen++;
            if (tx_axis_mac_tvalid && tx_axis_mac_tready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_beat: got data=%h last=%b want no beat",
                             cur.data, cur.last);
                end else begin
                    e = exp_q.pop_front();
                    check_beat("beat", cur, e);
                    if (e.last) lasts++;
                end
            end
            hold_v = tx_axis_mac_tvalid && !tx_axis_mac_tready;
            hold_b = cur;
        end
    end

    task automatic drive_beat(input beat_t b, input logic user, output int stalls);
        bit acc;
        acc = 1'b0;
        stalls = 0;
        s_axis_tdata  = b.data;
        s_axis_tkeep  = b.keep;
        s_axis_tlast  = b.last;
        s_axis_tuser  = user;
        s_axis_tvalid = 1'b1;
        while (!acc) begin
            @(negedge tx_clk);
            acc = s_axis_tready;
            @(posedge tx_clk);
            #1;
            if (!acc) begin
                stalls++;
                if (stalls > 5000) begin
                    n_bad++;
                    $display("FAIL s_axis_accept: no tready after %0d cycles, want acceptance", stalls);
                    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
                    $fatal(1, "write side stuck");
                end
            end
        end
    endtask

    // Model: a frame reaches the MAC only if it is good and fits; dropped frames give one pulse.
    task automatic send_frame(input int len, input bit bad, input bit oversize, output int stalls);
        beat_t fr[$];
        beat_t b;
        int    st;
        stalls = 0;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KEEP_W'($urandom);
            b.last = (i == len - 1);
            drive_beat(b, bad && b.last, st);
            stalls += st;
            fr.push_back(b);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (bad || oversize) begin
            drops_exp++;
        end else begin
            foreach (fr[k]) exp_q.push_back(fr[k]);
            commits++;
        end
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || tx_axis_mac_tvalid) && w < 20000) begin
            @(posedge tx_clk);
            #1;
            w++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d beats outstanding want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mac_tvalid"}, 64'(tx_axis_mac_tvalid), 64'(0));
        check({tag, "_mac_tlast"},  64'(tx_axis_mac_tlast),  64'(0));
        check({tag, "_mac_tuser"},  64'(tx_axis_mac_tuser),  64'(0));
        check({tag, "_drop_pulse"}, 64'(drop_pulse),         64'(0));
        check({tag, "_fifo_afull"}, 64'(fifo_afull),         64'(0));
        check({tag, "_s_tready"},   64'(s_axis_tready),      64'(1));
        check({tag, "_pkt_cnt"},    64'(pkt_cnt),            64'(0));
    endtask

    initial begin
        #900000;
        n_bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int    st;
        int    d0;
        beat_t b;
        sys_rst_n     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (3) @(posedge tx_clk);
        #1;
        sys_rst_n = 1'b1;
        check_reset("reset");

        // Single 4-beat frame: output valid two edges after the committing edge.
        rdy_fixed = 1'b1;
        send_frame(4, 1'b0, 1'b0, st);
        check("lat_edge0", 64'(tx_axis_mac_tvalid), 64'(0));
        @(posedge tx_clk); #1;
        check("lat_edge1", 64'(tx_axis_mac_tvalid), 64'(0));
        @(posedge tx_clk); #1;
        check("lat_edge2", 64'(tx_axis_mac_tvalid), 64'(1));
        wait_drain("single");

        // Bad frame then a good one.
        d0 = drops_seen;
        send_frame(3, 1'b1, 1'b0, st);
        send_frame(2, 1'b0, 1'b0, st);
        wait_drain("bad");
        check("bad_drop_pulses", 64'(drops_seen - d0), 64'(1));

        // Oversize frame: a single refusal when the buffer fills, then discard.
        d0 = drops_seen;
        send_frame(600, 1'b0, 1'b1, st);
        check("oversize_stalls", 64'(st), 64'(1));
        send_frame(8, 1'b0, 1'b0, st);
        wait_drain("oversize");
        check("oversize_drop_pulses", 64'(drops_seen - d0), 64'(1));

        // Back-pressure: fill with 64-beat frames while the MAC is stalled.
        rdy_fixed = 1'b0;
        for (int f = 0; f < 6; f++) begin
            send_frame(64, 1'b0, 1'b0, st);
            check("fill_no_stall", 64'(st), 64'(0));
        end
        repeat (2) begin @(posedge tx_clk); #1; end
        check("afull_below", 64'(fifo_afull), 64'(0));
        for (int f = 6; f < 8; f++) send_frame(64, 1'b0, 1'b0, st);
        repeat (2) begin @(posedge tx_clk); #1; end
        check("afull_above", 64'(fifo_afull), 64'(1));
        fork
            send_frame(64, 1'b0, 1'b0, st);
            begin
                int run;
                int w;
                run = 0;
                w = 0;
                while (run < 16 && w < 3000) begin
                    @(negedge tx_clk);
                    if (s_axis_tvalid && !s_axis_tready) run++;
                    else run = 0;
                    w++;
                end
                check("full_stall_seen", 64'(run), 64'(16));
                check("full_afull", 64'(fifo_afull), 64'(1));
                check("full_pkt_cnt", 64'(pkt_cnt), 64'(8));
                @(posedge tx_clk); #1;
                rdy_fixed = 1'b1;
            end
        join
        wait_drain("stall");
        check("stall_pkt_cnt_end", 64'(pkt_cnt), 64'(0));

        // Pointer wrap: 1000 random 7-beat frames, some bad, random MAC ready.
        d0 = drops_seen;
        st = drops_exp;
        rdy_rand = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int s2;
            send_frame(7, ($urandom_range(0, 9) == 0), 1'b0, s2);
            repeat ($urandom_range(0, 2)) begin @(posedge tx_clk); #1; end
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        wait_drain("wrap");
        check("wrap_drops", 64'(drops_seen - d0), 64'(drops_exp - st));

        // Reset during beat 3 of 5, then a clean frame.
        for (int i = 0; i < 2; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KEEP_W'($urandom);
            b.last = 1'b0;
            drive_beat(b, 1'b0, st);
        end
        s_axis_tdata = {$urandom, $urandom};
        sys_rst_n    = 1'b0;
        exp_q.delete();
        commits = 0;
        lasts   = 0;
        @(posedge tx_clk); #1;
        sys_rst_n     = 1'b1;
        s_axis_tvalid = 1'b0;
        check_reset("midreset");
        send_frame(5, 1'b0, 1'b0, st);
        wait_drain("midreset");
        check("midreset_pkt_cnt", 64'(pkt_cnt), 64'(0));

        check("drops_total", 64'(drops_seen), 64'(drops_exp));
        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ofm_pkt_fifo.md
Name: ofm_pkt_fifo

Overview:
- Parametrised single-clock store-and-forward TX packet FIFO in the tx_clk domain, sitting between the output frame mover and the 10G MAC transmit AXI-Stream port.
- Generalises the current TX data FIFO in three ways:
  - configurable data width and depth;
  - a MAC frame is released only once it is completely stored;
  - frames marked bad and frames too large for the buffer are dropped by rolling back the write pointer.

Parameters:
- DATA_W, 64, stream data width in bits; multiple of 8; KEEP_W = DATA_W/8.
- DEPTH_LOG2, 9, buffer depth = 2**DEPTH_LOG2 beats.
- PKT_LOG2, 8, committed-packet counter width; at most 2**PKT_LOG2-1 packets held.
- AFULL_THRESH, 448, used-beat count at or above which fifo_afull asserts.

Ports:
- tx_clk  in  1  clock, all logic rising-edge.
- sys_rst_n  in  1  synchronous active-low reset.
- s_axis_tdata  in  DATA_W  write beat data.
- s_axis_tkeep  in  KEEP_W  write byte enables.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  1  sampled on the tlast beat; 1 = bad frame, drop it.
- s_axis_tvalid  in  1  write valid.
- s_axis_tready  out  1  write ready.
- tx_axis_mac_tdata  out  DATA_W  read data.
- tx_axis_mac_tkeep  out  KEEP_W  read byte enables.
- tx_axis_mac_tlast  out  1  read last beat.
- tx_axis_mac_tuser  out  1  constant 0.
- tx_axis_mac_tvalid  out  1  read valid.
- tx_axis_mac_tready  in  1  MAC ready.
- fifo_afull  out  1  used beats >= AFULL_THRESH.
- pkt_cnt  out  PKT_LOG2  committed packets not yet fully read.
- drop_pulse  out  1  one-cycle pulse per dropped frame.

Behaviour:
- Reset state (sys_rst_n=0 at an edge): all pointers 0, pkt_cnt=0, tx_axis_mac_tvalid=0, tx_axis_mac_tlast=0, drop_pulse=0, fifo_afull=0, s_axis_tready=1.
- Reset mid-frame discards all stored and partial data.
- Storage is a simple dual-port RAM with 1-cycle read latency, followed by a one-entry output register.
- Entry width is DATA_W+KEEP_W+1 (data, keep, last).
- Pointers are DEPTH_LOG2+1 bits: wr_ptr (speculative), wr_commit, rd_ptr. used = wr_ptr - rd_ptr.
- Write FSM has two states, ST_STORE and ST_DISCARD.
- ST_STORE, beat accepted (tvalid & tready):
  - Write the beat at wr_ptr; wr_ptr++.
  - On tlast with tuser=0: wr_commit <= wr_ptr+1; pkt_cnt++.
  - On tlast with tuser=1: wr_ptr <= wr_commit; drop_pulse=1 next cycle.
- s_axis_tready in ST_STORE = ~full & (pkt_cnt != 2**PKT_LOG2-1), where full means used == 2**DEPTH_LOG2.
- Oversize handling, full & pkt_cnt==0 & read side idle:
  - The frame cannot fit; go to ST_DISCARD and set wr_ptr <= wr_commit.
  - drop_pulse asserts once, on entry.
- Plain full with pkt_cnt>0: stall (tready=0) until the reader frees space.
- ST_DISCARD: tready=1; beats are accepted and not stored; on the tlast beat, return to ST_STORE.
- Read side:
  - RAM is read while rd_ptr != wr_commit and the output register is empty or being consumed.
  - tx_axis_mac_tvalid is asserted exactly 2 cycles after the edge accepting a committed tlast, when the FIFO was previously empty.
  - Once valid, outputs hold stable until tx_axis_mac_tready=1.
  - Back-to-back beats at 1 beat/cycle under continuous tready.
  - pkt_cnt decrements on the edge where a tlast beat is accepted by the MAC.
  - Simultaneous commit and read-out of a last beat leaves pkt_cnt unchanged.
- Read never passes wr_commit: uncommitted beats are never visible.
- fifo_afull is registered from used, with 1-cycle lag.
- Wrap-around is handled by the extra pointer MSB; full/empty are distinguished by MSB inequality/equality.

Optional Feature:
- OFM_PKT_STATS_EN defined adds three outputs, each 32-bit wrapping and reset to 0:
  - stat_tx_pkts: counts tlast beats accepted by the MAC.
  - stat_drop_bad: counts tuser drops.
  - stat_drop_oversize: counts ST_DISCARD entries.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single frame, 4 beats, tuser=0, MAC tready=1: tvalid rises 2 cycles after tlast is accepted; 4 beats out with identical data/keep; tlast on beat 4; pkt_cnt goes 1 then 0.
- Bad frame, 3 beats with tuser=1 on tlast, followed by a good 2-beat frame: drop_pulse asserts once; only the 2-beat frame appears; wr_ptr ends at 2.
- Oversize frame of 600 beats with DEPTH_LOG2=9: enters ST_DISCARD at beat 512; drop_pulse=1 once; no MAC output; the following 8-beat frame passes intact.
- Stall: MAC tready=0, write 64-beat frames until full: s_axis_tready drops at used=512 and fifo_afull asserts at 448; tready=1 drains all 8 frames in order; pkt_cnt 8 → 0.
- Pointer wrap: stream 1000 frames of 7 beats, random MAC tready at 50%: zero data mismatch; pkt_cnt never exceeds 255.
- Reset mid-frame (sys_rst_n=0 for 1 cycle during beat 3 of 5): all outputs return to reset values; the next frame is output alone and correct.
